// File: rtl/pipe_dbg_pkg.sv
// Shared definitions for the UART debug controller:
// command opcodes, FSM states and packet sizing.
package pipe_dbg_pkg;

  localparam logic [7:0] OP_RESET = 8'h01;
  localparam logic [7:0] OP_STEP  = 8'h02;
  localparam logic [7:0] OP_RUN   = 8'h03;
  localparam logic [7:0] OP_STOP  = 8'h04;
  localparam logic [7:0] OP_STEPN = 8'h05;
  localparam logic [7:0] OP_DUMP  = 8'h06;

  localparam logic [7:0] HDR_DEF = 8'hA5;
  localparam logic [7:0] NAK_DEF = 8'hEE;

  typedef enum logic [3:0] {
    S_IDLE,
    S_GET_LO,
    S_GET_HI,
    S_PRST,
    S_STEPPING,
    S_RUNNING,
    S_SNAP,
    S_TX_HDR,
    S_TX_DATA,
    S_TX_CSUM,
    S_TX_WAIT
  } state_e;

  function automatic int nbytes(input int w);
    return (w + 7) / 8;
  endfunction

endpackage

// File: rtl/pipe_debug_ctrl_if.sv
// Byte-level link between the debug controller
// and the uart_rx / uart_tx pair.
interface pipe_debug_ctrl_if;

  logic       rx_done_tick;
  logic [7:0] rx_bus;
  logic       tx_done_tick;
  logic       tx_start;
  logic [7:0] tx_bus;

  modport master (
    input  rx_done_tick,
    input  rx_bus,
    input  tx_done_tick,
    output tx_start,
    output tx_bus
  );

  modport slave (
    output rx_done_tick,
    output rx_bus,
    output tx_done_tick,
    input  tx_start,
    input  tx_bus
  );

endinterface

// File: rtl/snap_serializer.sv
// Frozen copy of the pipeline state, presented one
// byte at a time with a running XOR checksum.
module snap_serializer
  import pipe_dbg_pkg::*;
#(
  parameter int SNAP_W = 2048
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              load_i,
  input  logic              adv_i,
  input  logic [SNAP_W-1:0] snap_i,
  output logic [7:0]        byte_o,
  output logic [7:0]        csum_o,
  output logic              last_o
);

  localparam int NB = nbytes(SNAP_W);
  localparam int IW = $clog2(NB + 1);

  logic [NB-1:0][7:0] shadow_q;
  logic [NB*8-1:0]    pad;
  logic [IW-1:0]      idx_q;
  logic [7:0]         csum_q;

  // top byte is zero-padded when SNAP_W is not a byte multiple
  always_comb begin
    pad = '0;
    pad[SNAP_W-1:0] = snap_i;
  end

  always_comb begin
    byte_o = '0;
    for (int i = 0; i < NB; i++) begin
      if (idx_q == IW'(i)) byte_o = shadow_q[i];
    end
  end

  always_ff @(posedge clk_i) begin
    if (load_i) shadow_q <= pad;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      idx_q  <= '0;
      csum_q <= '0;
    end else if (load_i) begin
      idx_q  <= '0;
      csum_q <= '0;
    end else if (adv_i) begin
      idx_q  <= idx_q + 1'b1;
      csum_q <= csum_q ^ byte_o;
    end
  end

  assign csum_o = csum_q;
  assign last_o = (idx_q == IW'(NB - 1));

endmodule

// File: rtl/pipe_debug_ctrl.sv
// UART command decoder that gates the pipeline clock enable
// and streams a framed, checksummed state snapshot back out.
module pipe_debug_ctrl
  import pipe_dbg_pkg::*;
#(
  parameter int         SNAP_W  = 2048,
  parameter int         CNT_W   = 16,
  parameter int         RST_CYC = 4,
  parameter logic [7:0] HDR     = HDR_DEF,
  parameter logic [7:0] NAK     = NAK_DEF
) (
  input  logic              top_clk,
  input  logic              top_rst,
  pipe_debug_ctrl_if.master uart,
  input  logic              halt,
  input  logic [SNAP_W-1:0] snapshot,
  output logic              pipe_en,
  output logic              pipe_rst_n,
  output logic              busy
);

  localparam int RC_W = $clog2(RST_CYC + 1);

  state_e           state_q;
  state_e           nxt_q;
  logic             pipe_en_q;
  logic             pipe_rst_n_q;
  logic             tx_start_q;
  logic [7:0]       tx_bus_q;
  logic [7:0]       lo_q;
  logic [CNT_W-1:0] rem_q;
  logic [RC_W-1:0]  rcnt_q;
  logic [CNT_W-1:0] n_d;
  logic             rx_stop;
  logic             ser_last;
  logic [7:0]       ser_byte;
  logic [7:0]       ser_csum;

  assign n_d     = CNT_W'({uart.rx_bus, lo_q});
  assign rx_stop = uart.rx_done_tick
                 && (uart.rx_bus == OP_STOP);

  snap_serializer #(.SNAP_W(SNAP_W)) u_ser (
    .clk_i  (top_clk),
    .rst_ni (top_rst),
    .load_i (state_q == S_SNAP),
    .adv_i  (state_q == S_TX_DATA),
    .snap_i (snapshot),
    .byte_o (ser_byte),
    .csum_o (ser_csum),
    .last_o (ser_last)
  );

  always_ff @(posedge top_clk) begin
    if (!top_rst) begin
      state_q      <= S_IDLE;
      nxt_q        <= S_IDLE;
      pipe_en_q    <= 1'b0;
      pipe_rst_n_q <= 1'b1;
      tx_start_q   <= 1'b0;
      tx_bus_q     <= '0;
      lo_q         <= '0;
      rem_q        <= '0;
      rcnt_q       <= '0;
    end else begin
      tx_start_q <= 1'b0;
      unique case (state_q)
        S_IDLE: if (uart.rx_done_tick) begin
          unique case (1'b1)
            uart.rx_bus == OP_RESET: begin
              pipe_rst_n_q <= 1'b0;
              rcnt_q       <= RC_W'(RST_CYC - 1);
              state_q      <= S_PRST;
            end
            uart.rx_bus == OP_STEP: begin
              pipe_en_q <= 1'b1;
              rem_q     <= '0;
              state_q   <= S_STEPPING;
            end
            uart.rx_bus == OP_RUN:   state_q <= S_RUNNING;
            uart.rx_bus == OP_STOP:  ;
            uart.rx_bus == OP_STEPN: state_q <= S_GET_LO;
            uart.rx_bus == OP_DUMP:  state_q <= S_SNAP;
            default: begin
              tx_bus_q   <= NAK;
              tx_start_q <= 1'b1;
              nxt_q      <= S_IDLE;
              state_q    <= S_TX_WAIT;
            end
          endcase
        end
        S_GET_LO: if (uart.rx_done_tick) begin
          lo_q    <= uart.rx_bus;
          state_q <= S_GET_HI;
        end
        S_GET_HI: if (uart.rx_done_tick) begin
          if (n_d == '0) begin
            state_q <= S_SNAP;
          end else begin
            pipe_en_q <= 1'b1;
            rem_q     <= n_d - 1'b1;
            state_q   <= S_STEPPING;
          end
        end
        S_PRST: begin
          if (rcnt_q == '0) begin
            pipe_rst_n_q <= 1'b1;
            state_q      <= S_IDLE;
          end else begin
            rcnt_q <= rcnt_q - 1'b1;
          end
        end
        S_STEPPING: begin
          if (rem_q == '0) begin
            pipe_en_q <= 1'b0;
            state_q   <= S_SNAP;
          end else begin
            rem_q <= rem_q - 1'b1;
          end
        end
        S_RUNNING: if (halt || rx_stop) state_q <= S_SNAP;
        S_SNAP: state_q <= S_TX_HDR;
        S_TX_HDR: begin
          tx_bus_q   <= HDR;
          tx_start_q <= 1'b1;
          nxt_q      <= S_TX_DATA;
          state_q    <= S_TX_WAIT;
        end
        S_TX_DATA: begin
          tx_bus_q   <= ser_byte;
          tx_start_q <= 1'b1;
          nxt_q      <= ser_last ? S_TX_CSUM : S_TX_DATA;
          state_q    <= S_TX_WAIT;
        end
        S_TX_CSUM: begin
          tx_bus_q   <= ser_csum;
          tx_start_q <= 1'b1;
          nxt_q      <= S_IDLE;
          state_q    <= S_TX_WAIT;
        end
        S_TX_WAIT: if (uart.tx_done_tick) state_q <= nxt_q;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // free run is gated by halt in the same cycle it is seen
  assign pipe_en = pipe_en_q
                 | ((state_q == S_RUNNING) & ~halt);
  assign pipe_rst_n    = pipe_rst_n_q;
  assign busy          = (state_q != S_IDLE);
  assign uart.tx_start = tx_start_q;
  assign uart.tx_bus   = tx_bus_q;

endmodule
